// File: rtl/ymux_rr_reg_if.sv
// rtl/ymux_rr_reg_if.sv - channel and output handshake bundle for ymux_rr_reg
interface ymux_rr_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    // Producer/consumer side: drives the channels and the output ready
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    // Multiplexer side
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/ymux_rr_reg.sv
// rtl/ymux_rr_reg.sv - N-to-1 word mux with fixed/round-robin select and registered output stage
module ymux_rr_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic          clk,
    input  logic          reset,
    ymux_rr_reg_if.slave  bus
);

    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_can_load;
    logic              w_found;
    logic [SEL_W-1:0]  w_scan;
    logic [SEL_W-1:0]  w_rr_idx;
    logic [SEL_W-1:0]  w_cand;
    logic              w_has_cand;
    logic              w_xfer;
    logic [NUM_IN-1:0] w_in_ready;
    logic [WIDTH-1:0]  w_cand_data;

    // The output register can take a word when empty or when it drains this cycle
    assign w_can_load = !r_out_valid || bus.out_ready;

    // Round-robin scan: first valid channel starting at the pointer, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_rr_idx = r_ptr;
        w_scan   = r_ptr;
        for (int k = 0; k < NUM_IN; k++) begin
            w_scan = r_ptr + SEL_W'(k);
            if (!w_found && bus.in_valid[w_scan]) begin
                w_found  = 1'b1;
                w_rr_idx = w_scan;
            end
        end
    end

    // In fixed mode the selected channel is always the candidate, so its ready
    // never depends on its own valid; in round-robin only a valid channel is offered
    assign w_cand     = bus.mode ? w_rr_idx : bus.sel;
    assign w_has_cand = bus.mode ? w_found : 1'b1;
    assign w_xfer     = w_has_cand && bus.in_valid[w_cand] && w_can_load && !reset;

    // One-hot ready on the candidate channel and the candidate's data word
    always_comb begin
        w_in_ready  = '0;
        w_cand_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (SEL_W'(i) == w_cand) begin
                w_in_ready[i] = w_can_load && w_has_cand && !reset;
                w_cand_data   = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage and round-robin pointer; reset discards any held word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_cand_data;
            r_out_sel   <= w_cand;
            r_out_valid <= 1'b1;
            if (bus.mode) begin
                r_ptr <= w_cand + SEL_W'(1);
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_ymux_rr_reg.sv
// tb/tb_ymux_rr_reg.sv - scoreboard bench for ymux_rr_reg
module tb_ymux_rr_reg;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [WIDTH-1:0] ch [NUM_IN];

    ymux_rr_reg_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    ymux_rr_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.in_data = {ch[3], ch[2], ch[1], ch[0]};

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH+SEL_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive, check ready mid-cycle, record expected word
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic ordy, input logic [3:0] exp_rdy,
                        input logic push, input logic [31:0] ed, input logic [1:0] es);
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        @(negedge clk);
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (push) exp_q.push_back({ed, es});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output word must match the scoreboard head
    initial begin
        logic [WIDTH+SEL_W-1:0] e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got data 0x%0h sel %0d, expected no word",
                             bus.out_data, bus.out_sel);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e[WIDTH+SEL_W-1:SEL_W]);
                    chk("out_sel", 32'(bus.out_sel), 32'(e[SEL_W-1:0]));
                end
            end
        end
    end

    initial begin
        ch[0] = 32'h11111111;
        ch[1] = 32'h22222222;
        ch[2] = 32'h33333333;
        ch[3] = 32'h44444444;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'h0);
        chk("reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset out_data", bus.out_data, 32'h0);
        chk("reset out_sel", 32'(bus.out_sel), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fixed select of channel 2, one word per cycle
        repeat (3) step(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'h33333333, 2'd2);

        // Round-robin from pointer 0 (held through fixed mode)
        for (int k = 0; k < 6; k++)
            step(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, ch[k % 4], 2'(k % 4));

        // Skip and wrap: ptr 2 -> grant 2, then 1, then 3, then wrap to 0
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'h33333333, 2'd2);
        step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1);
        step(1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 32'h44444444, 2'd3);
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h11111111, 2'd0);

        // Empty/drain: ptr stays 1
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);
        chk("drain out_valid", 32'(bus.out_valid), 32'h0);
        chk("drain out_data hold", bus.out_data, 32'h11111111);
        step(1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 32'h0, 2'd0);
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1);

        // Back-pressure holding 0xDEADBEEF, then load with no bubble
        ch[3] = 32'hDEADBEEF;
        step(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'hDEADBEEF, 2'd3);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0);
            chk("bp out_valid", 32'(bus.out_valid), 32'h1);
            chk("bp out_data", bus.out_data, 32'hDEADBEEF);
            chk("bp out_sel", 32'(bus.out_sel), 32'h3);
        end
        step(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h11111111, 2'd0);
        chk("no bubble out_valid", 32'(bus.out_valid), 32'h1);
        chk("no bubble out_data", bus.out_data, 32'h11111111);
        ch[3] = 32'h44444444;

        // Reset mid-operation with ptr 2
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);
        chk("pre-reset out_valid", 32'(bus.out_valid), 32'h0);
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b0, 32'h0, 2'd0);
        reset = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("mid reset in_ready", 32'(bus.in_ready), 32'h0);
        chk("mid reset held word", bus.out_data, 32'h33333333);
        @(posedge clk);
        #1;
        chk("post reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("post reset out_data", bus.out_data, 32'h0);
        chk("post reset out_sel", 32'(bus.out_sel), 32'h0);
        reset = 1'b0;
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h11111111, 2'd0);
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);

        chk("scoreboard empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ymux_rr_reg.md
Name: ymux_rr_reg

Overview:
Parametrised successor to the 4-to-1 word multiplexer. Selects one of NUM_IN WIDTH-bit input channels and registers the result into a single-entry output stage with valid/ready handshakes on every input channel and on the output. Two selection modes: fixed (external select) and round-robin arbitration across valid channels. Sits between multiple producers and one consumer in the datapath.

Parameters:
WIDTH, 32, data width per channel in bits
NUM_IN, 4, number of input channels; power of 2, minimum 2
SEL_W, 2, select/index width; equals log2(NUM_IN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  NUM_IN*WIDTH  flattened channels; channel i at bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  per-channel valid
in_ready  output  NUM_IN  per-channel ready (combinational)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used when mode = 0
out_data  output  WIDTH  registered selected word
out_sel  output  SEL_W  registered index of the channel that supplied out_data
out_valid  output  1  output stage holds a word
out_ready  input  1  consumer accepts the word this cycle

Behaviour:
- Reset (sampled on clk edge, reset=1): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. While reset=1, in_ready is all zeros.
- can_load = !out_valid || out_ready (output stage empty or draining this cycle).
- Grant selection, combinational, each cycle:
  - mode=0: candidate = sel; granted only if in_valid[sel]=1. Other channels are never granted.
  - mode=1: candidate = first i with in_valid[i]=1, scanning ptr, ptr+1, ... and wrapping modulo NUM_IN. No grant if all in_valid are 0.
- in_ready[i] = can_load && (i == candidate) && !reset. At most one bit of in_ready is high at a time. in_ready must not depend on in_valid in mode 0. In mode 1, in_ready is high only on the granted channel.
- Transfer on input channel i = in_valid[i] && in_ready[i]. On the next edge: out_data <= channel i data, out_sel <= i, out_valid <= 1.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_sel hold their last values.
- out_valid=1 and out_ready=0: out_data, out_sel and out_valid hold. No input is accepted (back-pressure).
- Latency: 1 cycle from input transfer to out_valid. Throughput: one word per cycle while out_ready=1.
- ptr updates only on a transfer in mode 1: ptr <= (granted index + 1) mod NUM_IN. Wrap-around: a grant of NUM_IN-1 gives ptr=0.
- ptr holds in mode 0 and holds when there is no grant. Round-robin resumes from the held ptr after a switch back to mode 1.
- mode and sel take effect in the same cycle they change, with no pipeline.
- Reset asserted mid-transfer wins: the pending word is discarded and all state returns to reset values on that edge.
- sel is SEL_W bits wide, so it is always in range.
- Arithmetic: the ptr increment is SEL_W-bit and wraps naturally.

Test Plan:
- Fixed select: mode=0, sel=2, all in_valid=1, channels=0x11111111/0x22222222/0x33333333/0x44444444, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x33333333, out_sel=2, out_valid=1; one word every cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1, from reset -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles; out_data matches each channel.
- Skip and wrap: mode=1, ptr=3 (after granting 2), in_valid=4'b0010 -> grant channel 1, ptr becomes 2. Then in_valid=4'b1000 -> grant 3, ptr wraps to 0.
- Back-pressure: out_valid=1 holding 0xDEADBEEF, out_ready=0 for 3 cycles -> in_ready=0, out_data/out_sel stable. On the out_ready=1 cycle a new word loads the same edge (no bubble).
- Empty/drain: all in_valid=0, out_ready=1 -> out_valid falls to 0 the next cycle, ptr unchanged. Mode 0 with in_valid[sel]=0 -> no transfer, in_ready[sel] still 1 if can_load.
- Reset mid-operation: streaming in mode 1 with ptr=2, assert reset for 1 cycle -> out_valid=0, out_data=0, out_sel=0, in_ready=0 during reset. After release, the first grant is channel 0.
